// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: owns the fetch PC and picks sequential, beq or jump next-PC with a one-cycle IF/ID flush
module branch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             eq_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic [15:0]      imm_i,
  input  logic [25:0]      jaddr_i,
  input  logic [31:0]      id_pc4_i,
  output logic [31:0]      pc_o,
  output logic             pc_valid_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, REDIRECT} state_t;
  state_t      state;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  assign br_tgt = id_pc4_i + {{14{imm_i[15]}}, imm_i, 2'b00};
  assign j_tgt  = {id_pc4_i[31:28], jaddr_i, 2'b00};
  // a stall defers the decision; only RUN can redirect, so reset/IDLE/REDIRECT keep flush low
  assign flush_o = (state == RUN) && !stall_i && (jump_i || (branch_i && eq_i));
  // next-PC selection, state sequencing and saturating redirect count
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state          <= IDLE;
      pc_o           <= RESET_PC;
      pc_valid_o     <= 1'b0;
      redirect_cnt_o <= '0;
    end else begin
      case (state)
        IDLE:
          if (start_i) begin
            state      <= RUN;
            pc_valid_o <= 1'b1;
          end
        RUN:
          if (flush_o) begin
            pc_o           <= jump_i ? j_tgt : br_tgt;
            state          <= REDIRECT;
            redirect_cnt_o <= (&redirect_cnt_o) ? redirect_cnt_o : redirect_cnt_o + CNT_W'(1);
          end else if (!stall_i) pc_o <= pc_o + 32'd4;
        REDIRECT:
          if (!stall_i) begin
            pc_o  <= pc_o + 32'd4;
            state <= RUN;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb_branch_pc_ctrl: directed plus random checks of branch_pc_ctrl against a behavioural PC model
module tb_branch_pc_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0, stall_i = 1'b0, eq_i = 1'b0, branch_i = 1'b0, jump_i = 1'b0;
  logic [15:0] imm_i = '0;
  logic [25:0] jaddr_i = '0;
  logic [31:0] id_pc4_i = '0;
  logic [31:0] pc_o, pc2;
  logic        pc_valid_o, flush_o, valid2, flush2;
  logic [15:0] redirect_cnt_o;
  logic [1:0]  cnt2;
  int vectors = 0, miscompares = 0;
  bit          m_started, m_redir;
  logic [31:0] m_pc;
  int          m_cnt16, m_cnt2;

  branch_pc_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .eq_i(eq_i),
    .branch_i(branch_i), .jump_i(jump_i), .imm_i(imm_i), .jaddr_i(jaddr_i), .id_pc4_i(id_pc4_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .flush_o(flush_o), .redirect_cnt_o(redirect_cnt_o)
  );

  branch_pc_ctrl #(.CNT_W(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i), .eq_i(eq_i),
    .branch_i(branch_i), .jump_i(jump_i), .imm_i(imm_i), .jaddr_i(jaddr_i), .id_pc4_i(id_pc4_i),
    .pc_o(pc2), .pc_valid_o(valid2), .flush_o(flush2), .redirect_cnt_o(cnt2)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pc", pc_o, m_pc);
    chk("pc_valid", {31'd0, pc_valid_o}, {31'd0, m_started});
    chk("cnt16", {16'd0, redirect_cnt_o}, m_cnt16);
    chk("cnt2", {30'd0, cnt2}, m_cnt2);
    chk("pc_w2", pc2, m_pc);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    m_started = 0; m_redir = 0; m_pc = 32'h0; m_cnt16 = 0; m_cnt2 = 0;
    chk_all();
    chk("flush_in_rst", {31'd0, flush_o}, 32'd0);
    #2 rst_i = 1'b0;
  endtask

  task automatic cyc(input bit st, input bit br, input bit eq, input bit j, input bit s,
                     input logic [15:0] imm, input logic [25:0] ja, input logic [31:0] pc4);
    bit          take;
    logic [31:0] tgt;
    @(negedge clk_i);
    start_i = st; branch_i = br; eq_i = eq; jump_i = j; stall_i = s;
    imm_i = imm; jaddr_i = ja; id_pc4_i = pc4;
    take = m_started && !m_redir && !s && (j || (br && eq));
    if (j) tgt = {pc4[31:28], ja, 2'b00};
    else   tgt = pc4 + 32'($signed(imm)) * 32'd4;
    #2;
    chk("flush", {31'd0, flush_o}, {31'd0, take});
    chk("flush_w2", {31'd0, flush2}, {31'd0, take});
    @(posedge clk_i);
    if (!m_started) m_started = st;
    else if (s) ;
    else if (take) begin
      m_pc = tgt; m_redir = 1;
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end else begin
      m_pc = m_pc + 32'd4; m_redir = 0;
    end
    #1;
    chk_all();
  endtask

  initial begin
    do_reset();
    cyc(0, 1, 1, 1, 0, 16'h3, 26'h1, 32'h20);
    chk("idle_pc", pc_o, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("start_pc", pc_o, 32'h0);
    chk("start_valid", {31'd0, pc_valid_o}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("seq_pc", pc_o, 32'(4 * i));
    end
    cyc(0, 1, 1, 0, 0, 16'h0003, 0, 32'h20);
    chk("beq_pc", pc_o, 32'h2C);
    chk("beq_cnt", {16'd0, redirect_cnt_o}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("after_beq", pc_o, 32'h30);
    cyc(0, 1, 1, 0, 0, 16'hFFFC, 0, 32'h40);
    chk("back_beq", pc_o, 32'h30);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 16'hFFFC, 0, 32'h40);
    chk("not_taken", pc_o, 32'h38);
    chk("nt_cnt", {16'd0, redirect_cnt_o}, 32'd2);
    cyc(0, 1, 1, 0, 1, 16'h0010, 0, 32'h100);
    cyc(0, 1, 1, 0, 1, 16'h0010, 0, 32'h100);
    chk("stall_hold", pc_o, 32'h38);
    cyc(0, 1, 1, 0, 0, 16'h0010, 0, 32'h100);
    chk("stall_release", pc_o, 32'h140);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("redir_stall", pc_o, 32'h140);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 16'h0001, 26'h0000040, 32'h1000_0008);
    chk("jump_pc", pc_o, 32'h1000_0100);
    cyc(0, 1, 1, 1, 0, 16'h0001, 26'h0000040, 32'h1000_0008);
    chk("redir_mask", pc_o, 32'h1000_0104);
    cyc(0, 1, 1, 0, 0, 16'hFFFF, 0, 32'h0);
    chk("br_wrap", pc_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("pc_wrap", pc_o, 32'h0);
    chk("sat2", {30'd0, cnt2}, 32'd3);
    cyc(0, 0, 0, 1, 0, 0, 26'h10, 32'h0);
    do_reset();
    chk("rst_mid_redir", pc_o, 32'h0);
    cyc(0, 0, 0, 1, 0, 0, 26'h10, 32'h0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
          16'($urandom), 26'($urandom), $urandom);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/branch_pc_ctrl.md
Name: branch_pc_ctrl

Overview:
- Sequential consumer of the ID-stage equality result; owns the program counter of the 5-stage pipeline.
- Each cycle it chooses the next PC: sequential PC+4, beq target, or jump target.
- On a redirect it raises a one-cycle flush to the IF/ID register.
- It holds PC on hazard stalls and counts taken redirects for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  level; leaves IDLE when sampled high.
- stall_i  input  1  load-use stall from hazard unit; hold PC.
- eq_i  input  1  1 when the two ID-stage register operands are equal.
- branch_i  input  1  ID-stage instruction is beq.
- jump_i  input  1  ID-stage instruction is j.
- imm_i  input  16  beq offset, in words.
- jaddr_i  input  26  j target field.
- id_pc4_i  input  32  PC+4 of the instruction in ID.
- pc_o  output  32  current fetch PC (registered).
- pc_valid_o  output  1  fetch address valid; 0 in IDLE.
- flush_o  output  1  combinational; zeroes IF/ID on the next edge.
- redirect_cnt_o  output  CNT_W  saturating count of redirects taken.

Behaviour:
- Reset (async, any time, including mid-redirect):
  - state=IDLE, pc_o=RESET_PC, pc_valid_o=0, redirect_cnt_o=0.
  - flush_o=0 while rst_i is high.
- Targets, all arithmetic modulo 2^32:
  - br_tgt = id_pc4_i + (sign_extend(imm_i) << 2).
  - j_tgt = {id_pc4_i[31:28], jaddr_i, 2'b00}.
- States: IDLE, RUN, REDIRECT.
- IDLE:
  - pc_o holds RESET_PC; flush_o=0; branch_i, jump_i, eq_i and stall_i are ignored.
  - start_i=1 -> RUN, and pc_valid_o=1 from the next cycle.
  - The first fetch uses RESET_PC; there is no increment on the transition.
- RUN, priority order per cycle:
  - (1) stall_i=1: pc_o holds, flush_o=0, no redirect. The branch decision is deferred because the operands are not yet valid. Stay in RUN.
  - (2) jump_i=1: pc_o<=j_tgt, flush_o=1, counter++, -> REDIRECT.
  - (3) branch_i=1 and eq_i=1: pc_o<=br_tgt, flush_o=1, counter++, -> REDIRECT.
  - (4) otherwise: pc_o<=pc_o+4, flush_o=0.
  - branch_i=1 with eq_i=0 (not taken) falls under (4); no flush.
  - jump_i and branch_i both high is an illegal decode; jump wins.
- REDIRECT (exactly one cycle):
  - ID holds the flushed bubble, so branch_i and jump_i are ignored.
  - flush_o=0.
  - stall_i=1: hold PC and stay in REDIRECT.
  - Otherwise pc_o<=pc_o+4 -> RUN.
- Latency:
  - Redirect decided in cycle N; pc_o shows the target in N+1.
  - Exactly one wrong-path instruction is fetched and flushed per taken branch or jump.
- Counter:
  - Increments by 1 per redirect.
  - Saturates at all-ones; no wrap.
- Wrap-around:
  - pc_o+4 from 32'hFFFF_FFFC gives 32'h0000_0000.
  - br_tgt wraps the same way.
- start_i has no effect outside IDLE; the block never returns to IDLE except by reset.

Test Plan:
- Reset then start: rst_i pulse, start_i=1 at cycle 2 -> pc_o=0 with pc_valid_o=0 until start; then 0, 4, 8, 12 on successive cycles.
- Taken beq: in RUN, id_pc4_i=0x20, imm_i=0x0003, branch_i=1, eq_i=1 -> flush_o=1 same cycle; pc_o=0x2C next cycle; redirect_cnt_o=1; then pc_o=0x30.
- Backward branch and not-taken: imm_i=16'hFFFC, id_pc4_i=0x40, eq_i=1 -> pc_o=0x30. Repeat with eq_i=0 -> flush_o=0, pc_o=prev+4, counter unchanged.
- Stall priority: stall_i=1 together with branch_i=1, eq_i=1 for 2 cycles -> pc_o held, flush_o=0. Stall drops with the branch still taken -> redirect occurs then.
- Jump over branch, REDIRECT masking:
  - id_pc4_i=0x1000_0008, jaddr_i=0x0000040, jump_i=1, branch_i=1, eq_i=1 -> pc_o=0x1000_0100.
  - In the following REDIRECT cycle, jump_i=1 again -> ignored; pc_o=0x1000_0104.
- Reset mid-redirect and saturation:
  - Assert rst_i while in REDIRECT -> immediate pc_o=RESET_PC, state IDLE, flush_o=0.
  - With CNT_W=2, 5 redirects -> redirect_cnt_o=3.
